shift_deserializer: RTL and testbench
=====================================

Name: shift_deserializer

Overview:
- Parametrised successor to the single-shot 17-bit shift buffer.
- Collects a serial bit stream (valid/ready) into WIDTH-bit words and presents them on a valid/ready word stream.
- Generalised in word width, bit order and run mode (continuous or one-shot).
- Adds a word output register so a new word can assemble while the previous one waits for the consumer.
- Sits between a bit-level receiver (pin sampler, slow-domain bridge output) and word-level core logic in the Core_clk domain.

Parameters:
WIDTH, 17, word width in bits (>=2).
MSB_FIRST, 1, 1: first received bit lands in payload[WIDTH-1]; 0: first received bit lands in payload[0].
ONE_SHOT, 0, 1: stop after one delivered word until io_resetBuffer; 0: re-arm automatically.

Ports:
Core_clk  input  1  clock; all logic on rising edge.
Core_reset  input  1  synchronous, active-high reset.
io_dataIn_valid  input  1  serial bit valid.
io_dataIn_ready  output  1  serial bit accepted when valid && ready.
io_dataIn_payload  input  1  serial bit.
io_dataOut_valid  output  1  word valid.
io_dataOut_ready  input  1  consumer accepts word when valid && ready.
io_dataOut_payload  output  WIDTH  assembled word.
io_resetBuffer  input  1  synchronous soft clear (discard partial and pending words, re-arm).
io_bitCount  output  clog2(WIDTH+1)  bits currently held in the shift register.
io_done  output  1  ONE_SHOT only: word delivered, block idle until re-armed; tied 0 when ONE_SHOT=0.

Behaviour:
- Reset and soft clear: Core_reset or io_resetBuffer asserted at an edge clears the following:
  - shift register to 0, bit counter to 0, full flag, output register valid, done flag.
  - After either, all outputs are 0 except io_dataIn_ready=1. The payload register is also cleared to 0.
  - Core_reset has priority over io_resetBuffer, which has priority over all normal activity in the same cycle. A bit or word handshake coinciding with either clear is discarded.
- Bit acceptance:
  - io_dataIn_ready = !full && !done.
  - Each accepted bit increments the counter.
  - MSB_FIRST=1: shift left, new bit enters bit 0.
  - MSB_FIRST=0: shift right, new bit enters bit WIDTH-1.
- Word completion, when a bit is accepted with counter==WIDTH-1:
  - Output register free (dataOut_valid==0, or dataOut_valid && dataOut_ready this cycle): the completed word (including the new bit) loads the payload register. dataOut_valid=1 next cycle, counter returns to 0. Latency is 1 cycle from last-bit handshake to word valid.
  - Output register occupied and not being read: the word stays in the shift register, full=1, counter=WIDTH, io_dataIn_ready=0.
- Full drain: while full, the first cycle the output register frees moves the word into it. Next cycle: full=0, counter=0, dataIn_ready=1, dataOut_valid=1.
- Output hold: payload and valid stay stable while valid && !ready. Valid deasserts the cycle after a handshake unless a new word loads that same edge; back-to-back words are allowed.
- Throughput: continuous mode sustains 1 bit/cycle with the consumer always ready. There is no bubble between words.
- ONE_SHOT=1:
  - On the first word handshake, done=1.
  - While done: dataIn_ready=0, no further words are produced.
  - A word already complete in the shift register is held but not delivered.
  - Only io_resetBuffer or Core_reset clears done.
- io_bitCount: registered value of the counter, 0..WIDTH.

Test Plan:
- WIDTH=8, MSB_FIRST=1, consumer always ready, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> dataOut_valid=1 with payload 0xB2 exactly 1 cycle after the 8th bit; io_bitCount back to 0.
- Same bits with MSB_FIRST=0 -> payload 0x4D.
- WIDTH=8, consumer held not ready, 16 bits 0xA5 then 0x3C (MSB first) -> first word 0xA5 held stable. After the 16th bit: dataIn_ready=0, io_bitCount=8. Releasing ready delivers 0xA5, then 0x3C next cycle, then dataIn_ready=1.
- Continuous 1 bit/cycle for 4 words, consumer always ready -> a valid word every 8 cycles, no dropped bits, dataIn_ready never low.
- ONE_SHOT=1, WIDTH=17, 17 bits of 0x1ABCD delivered, then 5 more valid bits -> io_done=1 and dataIn_ready=0. A later io_resetBuffer pulse makes io_done=0, dataIn_ready=1, io_bitCount=0.
- io_resetBuffer after 5 of 8 bits, with a word also pending on the output -> next cycle dataOut_valid=0, io_bitCount=0. A fresh 8 bits 0xFF yields 0xFF with no residue from the discarded bits.

Source files
------------

// File: rtl/shift_deserializer.sv
// Serial-to-parallel word assembler: gathers valid/ready bits into WIDTH-bit words
// and hands them out through a one-deep output register, in continuous or one-shot mode.
module shift_deserializer #(
    parameter int WIDTH     = 17,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit ONE_SHOT  = 1'b0
) (
    input  logic                       Core_clk,
    input  logic                       Core_reset,
    input  logic                       io_dataIn_valid,
    output logic                       io_dataIn_ready,
    input  logic                       io_dataIn_payload,
    output logic                       io_dataOut_valid,
    input  logic                       io_dataOut_ready,
    output logic [WIDTH-1:0]           io_dataOut_payload,
    input  logic                       io_resetBuffer,
    output logic [$clog2(WIDTH+1)-1:0] io_bitCount,
    output logic                       io_done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

    // Both streams: a transfer happens on a rising edge where valid && ready;
    // a producer holds valid and payload steady until that edge.

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] payload_q, payload_d;
    logic             done_q, done_d;

    logic             in_ready;
    logic             bit_fire;
    logic             out_fire;
    logic             out_free;
    logic             load_ok;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        in_ready = !full_q && !done_q;
        bit_fire = io_dataIn_valid && in_ready;
        out_fire = out_valid_q && io_dataOut_ready;
        out_free = !out_valid_q || io_dataOut_ready;
        // In one-shot mode nothing new may enter the output register once the first word has gone.
        load_ok  = out_free && !(ONE_SHOT && (done_q || out_fire));

        if (MSB_FIRST) begin
            shifted = {shift_q[WIDTH-2:0], io_dataIn_payload};
        end else begin
            shifted = {io_dataIn_payload, shift_q[WIDTH-1:1]};
        end

        shift_d     = shift_q;
        count_d     = count_q;
        full_d      = full_q;
        out_valid_d = out_valid_q;
        payload_d   = payload_q;
        done_d      = done_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
            if (ONE_SHOT) begin
                done_d = 1'b1;
            end
        end

        if (full_q && load_ok) begin
            payload_d   = shift_q;
            out_valid_d = 1'b1;
            full_d      = 1'b0;
            count_d     = '0;
            shift_d     = '0;
        end else if (bit_fire) begin
            if (count_q == LAST_BIT) begin
                if (load_ok) begin
                    payload_d   = shifted;
                    out_valid_d = 1'b1;
                    count_d     = '0;
                    shift_d     = '0;
                end else begin
                    shift_d = shifted;
                    full_d  = 1'b1;
                    count_d = FULL_CNT;
                end
            end else begin
                shift_d = shifted;
                count_d = count_q + 1'b1;
            end
        end

        if (io_resetBuffer) begin
            shift_d     = '0;
            count_d     = '0;
            full_d      = 1'b0;
            out_valid_d = 1'b0;
            payload_d   = '0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge Core_clk) begin
        if (Core_reset) begin
            shift_q     <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            payload_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            count_q     <= count_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            payload_q   <= payload_d;
            done_q      <= done_d;
        end
    end

    assign io_dataIn_ready    = in_ready;
    assign io_dataOut_valid   = out_valid_q;
    assign io_dataOut_payload = payload_q;
    assign io_bitCount        = count_q;
    assign io_done            = ONE_SHOT ? done_q : 1'b0;

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: three configurations checked every cycle against a
// queue-based model, plus directed word sequences with literal expectations.
module tb_shift_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic iv[3], ib[3], ordy[3], clr[3];

  logic       a_rdy, a_ov, a_done;
  logic [7:0] a_pay;
  logic [3:0] a_cnt;
  logic       b_rdy, b_ov, b_done;
  logic [7:0] b_pay;
  logic [3:0] b_cnt;
  logic        c_rdy, c_ov, c_done;
  logic [16:0] c_pay;
  logic [4:0]  c_cnt;

  shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .ONE_SHOT(1'b0)) dut_a (
    .Core_clk(clk), .Core_reset(rst),
    .io_dataIn_valid(iv[0]), .io_dataIn_ready(a_rdy), .io_dataIn_payload(ib[0]),
    .io_dataOut_valid(a_ov), .io_dataOut_ready(ordy[0]), .io_dataOut_payload(a_pay),
    .io_resetBuffer(clr[0]), .io_bitCount(a_cnt), .io_done(a_done)
  );

  shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0), .ONE_SHOT(1'b0)) dut_b (
    .Core_clk(clk), .Core_reset(rst),
    .io_dataIn_valid(iv[1]), .io_dataIn_ready(b_rdy), .io_dataIn_payload(ib[1]),
    .io_dataOut_valid(b_ov), .io_dataOut_ready(ordy[1]), .io_dataOut_payload(b_pay),
    .io_resetBuffer(clr[1]), .io_bitCount(b_cnt), .io_done(b_done)
  );

  shift_deserializer #(.WIDTH(17), .MSB_FIRST(1'b1), .ONE_SHOT(1'b1)) dut_c (
    .Core_clk(clk), .Core_reset(rst),
    .io_dataIn_valid(iv[2]), .io_dataIn_ready(c_rdy), .io_dataIn_payload(ib[2]),
    .io_dataOut_valid(c_ov), .io_dataOut_ready(ordy[2]), .io_dataOut_payload(c_pay),
    .io_resetBuffer(clr[2]), .io_bitCount(c_cnt), .io_done(c_done)
  );

  logic        o_rdy[3], o_v[3], o_done[3];
  logic [31:0] o_pay[3], o_cnt[3];
  assign o_rdy[0] = a_rdy;  assign o_v[0] = a_ov;  assign o_done[0] = a_done;
  assign o_rdy[1] = b_rdy;  assign o_v[1] = b_ov;  assign o_done[1] = b_done;
  assign o_rdy[2] = c_rdy;  assign o_v[2] = c_ov;  assign o_done[2] = c_done;
  assign o_pay[0] = 32'(a_pay);  assign o_cnt[0] = 32'(a_cnt);
  assign o_pay[1] = 32'(b_pay);  assign o_cnt[1] = 32'(b_cnt);
  assign o_pay[2] = 32'(c_pay);  assign o_cnt[2] = 32'(c_cnt);

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: accepted bits kept as a list, words formed from the list by bit order.
  int          mw[3]   = '{8, 8, 17};
  bit          mmsb[3] = '{1'b1, 1'b0, 1'b1};
  bit          mos[3]  = '{1'b0, 1'b0, 1'b1};
  bit          mbits[3][$];
  logic        mv[3];
  logic [31:0] mword[3];
  logic        mdone[3];

  function automatic logic [31:0] pack_word(input int k);
    logic [31:0] wd;
    wd = '0;
    for (int i = 0; i < mw[k]; i++) begin
      if (mmsb[k]) wd[mw[k] - 1 - i] = mbits[k][i];
      else         wd[i] = mbits[k][i];
    end
    return wd;
  endfunction

  function automatic logic model_ready(input int k);
    return (mbits[k].size() < mw[k]) && !mdone[k];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst || clr[k]) begin
          mbits[k].delete();
          mv[k]    = 1'b0;
          mword[k] = '0;
          mdone[k] = 1'b0;
        end else begin
          logic fire, free, allow, rdy;
          fire  = mv[k] && ordy[k];
          free  = !mv[k] || ordy[k];
          rdy   = model_ready(k);
          allow = free && !(mos[k] && (mdone[k] || fire));
          if (fire) begin
            mv[k] = 1'b0;
            if (mos[k]) mdone[k] = 1'b1;
          end
          if (rdy && iv[k]) mbits[k].push_back(ib[k]);
          if (mbits[k].size() == mw[k] && allow) begin
            mword[k] = pack_word(k);
            mv[k]    = 1'b1;
            mbits[k].delete();
          end
        end
      end
    end
  end

  // Compare process: every output of every instance on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int k = 0; k < 3; k++) begin
          check1($sformatf("valid[%0d]", k), o_v[k], mv[k]);
          checkw($sformatf("payload[%0d]", k), o_pay[k], mword[k]);
          check1($sformatf("in_ready[%0d]", k), o_rdy[k], model_ready(k));
          checkw($sformatf("bit_count[%0d]", k), o_cnt[k], 32'(mbits[k].size()));
          check1($sformatf("done[%0d]", k), o_done[k], mdone[k]);
        end
      end
    end
  end

  task automatic send_bits(input logic [31:0] bits_v, input int n, input logic [2:0] mask);
    for (int i = n - 1; i >= 0; i--) begin
      for (int k = 0; k < 3; k++) begin
        if (mask[k]) begin
          iv[k] = 1'b1;
          ib[k] = bits_v[i];
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) if (mask[k]) iv[k] = 1'b0;
  endtask

  initial begin
    int nval, nlow, nspace;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ib[k] = 1'b0; ordy[k] = 1'b0; clr[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    armed = 1'b1;
    rst   = 1'b0;
    check1("rst_valid", a_ov, 1'b0);
    check1("rst_in_ready", a_rdy, 1'b1);
    checkw("rst_count", 32'(a_cnt), 32'd0);
    checkw("rst_payload", 32'(c_pay), 32'd0);
    check1("rst_done", c_done, 1'b0);

    // 1,0,1,1,0,0,1,0 into both bit orders, consumer ready
    ordy[0] = 1'b1; ordy[1] = 1'b1;
    send_bits(32'hB2, 8, 3'b011);
    check1("msb_word_valid", a_ov, 1'b1);
    checkw("msb_word", 32'(a_pay), 32'hB2);
    checkw("lsb_word", 32'(b_pay), 32'h4D);
    checkw("count_after_word", 32'(a_cnt), 32'd0);
    @(negedge clk);
    check1("valid_drops", a_ov, 1'b0);

    // Stalled consumer: 0xA5 waits in the output register, 0x3C fills the shifter
    ordy[0] = 1'b0; ordy[1] = 1'b0;
    send_bits(32'hA53C, 16, 3'b011);
    checkw("held_word", 32'(a_pay), 32'hA5);
    check1("full_not_ready", a_rdy, 1'b0);
    checkw("full_count", 32'(a_cnt), 32'd8);
    @(negedge clk);
    checkw("held_word_stable", 32'(a_pay), 32'hA5);
    ordy[0] = 1'b1; ordy[1] = 1'b1;
    @(negedge clk);
    checkw("second_word", 32'(a_pay), 32'h3C);
    check1("second_valid", a_ov, 1'b1);
    check1("drained_ready", a_rdy, 1'b1);
    @(negedge clk);
    check1("drained_idle", a_ov, 1'b0);

    // Continuous stream: four words, one bit per cycle
    nval = 0; nlow = 0; nspace = 0;
    for (int t = 1; t <= 32; t++) begin
      iv[0] = 1'b1;
      ib[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (a_ov) nval++;
      if (a_ov !== ((t % 8) == 0)) nspace++;
      if (!a_rdy) nlow++;
    end
    iv[0] = 1'b0;
    checkw("stream_words", 32'(nval), 32'd4);
    checkw("stream_spacing_errs", 32'(nspace), 32'd0);
    checkw("stream_ready_lows", 32'(nlow), 32'd0);

    // One-shot 17-bit word, then extra bits after delivery
    ordy[2] = 1'b1;
    send_bits(32'h1ABCD, 17, 3'b100);
    check1("oneshot_valid", c_ov, 1'b1);
    checkw("oneshot_word", 32'(c_pay), 32'h1ABCD);
    check1("oneshot_not_done_yet", c_done, 1'b0);
    send_bits(32'h16, 5, 3'b100);
    check1("oneshot_done", c_done, 1'b1);
    check1("oneshot_blocked", c_rdy, 1'b0);
    check1("oneshot_no_second", c_ov, 1'b0);
    clr[2] = 1'b1;
    @(negedge clk);
    clr[2] = 1'b0;
    check1("rearm_done", c_done, 1'b0);
    check1("rearm_ready", c_rdy, 1'b1);
    checkw("rearm_count", 32'(c_cnt), 32'd0);

    // Soft clear with a pending word and a partial word; a bit offered that edge is dropped
    ordy[0] = 1'b0;
    send_bits(32'h5A, 8, 3'b001);
    send_bits(32'h1F, 5, 3'b001);
    check1("pre_clear_valid", a_ov, 1'b1);
    checkw("pre_clear_count", 32'(a_cnt), 32'd5);
    clr[0] = 1'b1; iv[0] = 1'b1; ib[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0; iv[0] = 1'b0;
    check1("clear_valid", a_ov, 1'b0);
    checkw("clear_count", 32'(a_cnt), 32'd0);
    checkw("clear_payload", 32'(a_pay), 32'd0);
    ordy[0] = 1'b1;
    send_bits(32'hFF, 8, 3'b001);
    checkw("fresh_word", 32'(a_pay), 32'hFF);
    check1("fresh_valid", a_ov, 1'b1);

    // Random traffic on all instances, with occasional soft clears and resets
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int k = 0; k < 3; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        ib[k]   = 1'($urandom_range(0, 1));
        ordy[k] = ($urandom_range(0, 2) != 0);
        clr[k]  = ($urandom_range(0, 99) == 0);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; clr[k] = 1'b0; ordy[k] = 1'b1;
    end
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
